// File: rtl/minne_pkg.sv
// Shared constants and helpers for the minne row encoder queue.
package minne_pkg;

  localparam int N_REQ  = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OFFER = 1'b1;

  function automatic logic [CNT_W-1:0] popcount8(input logic [N_REQ-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < N_REQ; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/pick_first8.sv
// Combinational find-first-set over 8 request bits, searching upward from a
// start index with wrap-around.
module pick_first8
  import minne_pkg::*;
(
  input  logic [N_REQ-1:0]  req,
  input  logic [ADDR_W-1:0] start,
  output logic [ADDR_W-1:0] idx,
  output logic              found
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] shifted;
  logic [N_REQ-1:0]   rot;

  // rot[i] is request (start + i) mod 8, so the lowest set bit of rot is the winner
  assign dbl     = {req, req};
  assign shifted = dbl >> start;
  assign rot     = shifted[N_REQ-1:0];

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    idx   = '0;
    found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        idx   = start + ADDR_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder8to3_queue.sv
// Queues 8 row request lines as pending bits and serialises them as 3-bit row
// addresses over Valid/Ready. Define ENC_ROUND_ROBIN_EN for round-robin picking.
module encoder8to3_queue
  import minne_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Select,
  input  logic              Load,
  input  logic [N_REQ-1:0]  Z,
  input  logic              Clear,
  input  logic              Ready,
  output logic [ADDR_W-1:0] A,
  output logic              Valid,
  output logic [CNT_W-1:0]  Count,
  output logic              Overrun
);

  logic [N_REQ-1:0]  pend;
  logic [N_REQ-1:0]  pend_next;
  logic [N_REQ-1:0]  pop_mask;
  logic [N_REQ-1:0]  load_bits;
  logic              state;
  logic              pop;
  logic              hold;
  logic [ADDR_W-1:0] start;
  logic [ADDR_W-1:0] pick_idx;
  logic              pick_found;

  assign Valid     = (state == ST_OFFER);
  assign pop       = Valid & Ready;
  assign pop_mask  = pop ? (N_REQ'(1) << A) : '0;
  assign load_bits = (Load & Select) ? Z : '0;
  assign pend_next = Clear ? '0 : ((pend & ~pop_mask) | load_bits);
  // An offered address must not change under the consumer while it stalls
  assign hold      = Valid & ~Ready & ~Clear;

`ifdef ENC_ROUND_ROBIN_EN
  logic [ADDR_W-1:0] rr_ptr;
  logic [ADDR_W-1:0] rr_ptr_next;

  // rr_ptr holds the next search start, i.e. last popped row + 1
  assign rr_ptr_next = pop ? (A + ADDR_W'(1)) : rr_ptr;
  assign start       = rr_ptr_next;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) rr_ptr <= '0;
    else        rr_ptr <= rr_ptr_next;
  end
`else
  assign start = '0;
`endif

  pick_first8 u_pick (
    .req   (pend_next),
    .start (start),
    .idx   (pick_idx),
    .found (pick_found)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend    <= '0;
      state   <= ST_IDLE;
      A       <= '0;
      Count   <= '0;
      Overrun <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      pend  <= pend_next;
      state <= (pend_next != '0) ? ST_OFFER : ST_IDLE;
      Count <= popcount8(pend_next);
      if (!hold) A <= pick_found ? pick_idx : '0;
      if (Clear)                                    Overrun <= 1'b0;
      else if ((load_bits & pend & ~pop_mask) != '0) Overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder8to3_queue.sv
// Self-checking bench for encoder8to3_queue: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural queue model.
module tb_encoder8to3_queue;

  logic       Clk;
  logic       Rst_n;
  logic       Select;
  logic       Load;
  logic [7:0] Z;
  logic       Clear;
  logic       Ready;
  logic [2:0] A;
  logic       Valid;
  logic [3:0] Count;
  logic       Overrun;

  int n_checks = 0;
  int n_errors = 0;

  encoder8to3_queue dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .Select  (Select),
    .Load    (Load),
    .Z       (Z),
    .Clear   (Clear),
    .Ready   (Ready),
    .A       (A),
    .Valid   (Valid),
    .Count   (Count),
    .Overrun (Overrun)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       sel;
    logic       load;
    logic [7:0] z;
    logic       clr;
    logic       rdy;
    logic [2:0] a;
    logic       v;
    logic [3:0] c;
    logic       o;
  } vec_t;

  vec_t tbl [19];

  // Behavioural model: a set of pending rows, the offered row and a search start.
  bit [7:0] m_pend;
  int       m_a;
  bit       m_valid;
  bit       m_ovr;
  int       m_ptr;

  function automatic logic [15:0] pk(logic [2:0] a, logic v, logic [3:0] c, logic o);
    return {7'd0, a, v, c, o};
  endfunction

  function automatic logic [15:0] dut_pk();
    return pk(A, Valid, Count, Overrun);
  endfunction

  function automatic logic [15:0] model_pk();
    int cnt;
    cnt = 0;
    for (int r = 0; r < 8; r++) cnt += int'(m_pend[r]);
    return pk(3'(m_a), m_valid, 4'(cnt), m_ovr);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got A=%0d V=%0d C=%0d O=%0d, expected A=%0d V=%0d C=%0d O=%0d",
               name, got[8:6], got[5], got[4:1], got[0], exp[8:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_a     = 0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_ptr   = 0;
  endtask

  task automatic model_step(input bit sel, input bit load, input bit [7:0] z,
                            input bit clr, input bit rdy);
    bit       pop;
    bit       hit;
    bit [7:0] nxt;
    pop = m_valid && rdy;
    hit = 1'b0;
    for (int r = 0; r < 8; r++) begin
      bit keep;
      bit req;
      keep = m_pend[r] && !(pop && r == m_a);
      req  = sel && load && z[r];
      if (keep && req) hit = 1'b1;
      nxt[r] = !clr && (keep || req);
    end
    if (clr)      m_ovr = 1'b0;
    else if (hit) m_ovr = 1'b1;
`ifdef ENC_ROUND_ROBIN_EN
    if (pop) m_ptr = (m_a + 1) % 8;
`endif
    if (!(m_valid && !rdy && !clr)) begin
      m_a = 0;
      for (int k = 7; k >= 0; k--)
        if (nxt[(m_ptr + k) % 8]) m_a = (m_ptr + k) % 8;
    end
    m_pend  = nxt;
    m_valid = (nxt != 0);
  endtask

  task automatic drive(input logic sel, input logic load, input logic [7:0] z,
                       input logic clr, input logic rdy);
    Select = sel;
    Load   = load;
    Z      = z;
    Clear  = clr;
    Ready  = rdy;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'hA4, 1'b0, 1'b0, 3'd2, 1'b1, 4'd3, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd5, 1'b1, 4'd2, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd7, 1'b1, 4'd1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 3'd4, 1'b1, 4'd1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd4, 1'b1, 4'd2, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 4'd1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 3'd0, 1'b1, 4'd2, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b0, 3'd3, 1'b1, 4'd1, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 8'h08, 1'b0, 1'b1, 3'd3, 1'b1, 4'd1, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 4'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 8'h30, 1'b0, 1'b0, 3'd4, 1'b1, 4'd2, 1'b0};
    tbl[15] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 3'd5, 1'b1, 4'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0, 1'b0};
    tbl[17] = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};
    tbl[18] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0};

    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", dut_pk(), pk(3'd0, 1'b0, 4'd0, 1'b0));
    Rst_n = 1'b1;

    // Asynchronous reset in the middle of an offer
    drive(1'b1, 1'b1, 8'h24, 1'b0, 1'b0);
    tick();
    check("rst_pre_offer", dut_pk(), pk(3'd2, 1'b1, 4'd2, 1'b0));
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    Rst_n = 1'b0;
    #1;
    check("rst_async", dut_pk(), pk(3'd0, 1'b0, 4'd0, 1'b0));
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].sel, tbl[i].load, tbl[i].z, tbl[i].clr, tbl[i].rdy);
      tick();
      check($sformatf("vec%0d", i), dut_pk(), pk(tbl[i].a, tbl[i].v, tbl[i].c, tbl[i].o));
    end

    // Full pending set: Count saturates at 8, re-request flags Overrun
    do_reset();
    drive(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    tick();
    check("full_load", dut_pk(), pk(3'd0, 1'b1, 4'd8, 1'b0));
    tick();
    check("full_reload", dut_pk(), pk(3'd0, 1'b1, 4'd8, 1'b1));

    // Pop of row 0 with simultaneous re-request of row 0
    do_reset();
    drive(1'b1, 1'b1, 8'h81, 1'b0, 1'b0);
    tick();
    check("rr_load", dut_pk(), pk(3'd0, 1'b1, 4'd2, 1'b0));
    drive(1'b1, 1'b1, 8'h01, 1'b0, 1'b1);
    tick();
`ifdef ENC_ROUND_ROBIN_EN
    check("rr_after_pop0", dut_pk(), pk(3'd7, 1'b1, 4'd2, 1'b0));
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check("rr_wrap", dut_pk(), pk(3'd0, 1'b1, 4'd1, 1'b0));
`else
    check("fp_after_pop0", dut_pk(), pk(3'd0, 1'b1, 4'd2, 1'b0));
    drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    check("fp_next", dut_pk(), pk(3'd7, 1'b1, 4'd1, 1'b0));
`endif
    tick();
    check("rr_drained", dut_pk(), pk(3'd0, 1'b0, 4'd0, 1'b0));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic       sel;
      logic       load;
      logic [7:0] z;
      logic       clr;
      logic       rdy;
      sel  = ($urandom_range(0, 3) != 0);
      load = $urandom_range(0, 1) == 1;
      z    = 8'($urandom) & 8'($urandom);
      clr  = ($urandom_range(0, 31) == 0);
      rdy  = ($urandom_range(0, 2) != 0);
      drive(sel, load, z, clr, rdy);
      model_step(sel, load, z, clr, rdy);
      tick();
      check($sformatf("rand%0d", i), dut_pk(), model_pk());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
